// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the PWM duty-cycle controller family.
//   - pwm_state_e : controller state (IDLE, ARMED, RAMP)
//   - *_DEF       : default channel geometry
//   - duty_wide_t : wide working type so the helpers serve any DUTY_W <= 16
//   - clamp_duty  : limit a requested duty to the largest legal value
//   - step_toward : move a duty one count towards a target (no move if equal)
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2
  } pwm_state_e;

  localparam int DUTY_W_DEF       = 4;
  localparam int PERIOD_DEF       = 11;
  localparam int MAX_DUTY_DEF     = 11;
  localparam int STEP_PERIODS_DEF = 4;

  localparam int DUTY_WIDE = 16;
  typedef logic [DUTY_WIDE-1:0] duty_wide_t;

  function automatic duty_wide_t clamp_duty(input duty_wide_t value,
                                            input duty_wide_t limit);
    return (value > limit) ? limit : value;
  endfunction

  // Never leaves the interval between cur and tgt, so a duty that starts
  // in 0..MAX_DUTY and heads to a clamped target stays in range.
  function automatic duty_wide_t step_toward(input duty_wide_t cur,
                                             input duty_wide_t tgt);
    if (cur < tgt) begin
      return cur + duty_wide_t'(1);
    end else if (cur > tgt) begin
      return cur - duty_wide_t'(1);
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if
//   Target-duty handshake between the command side and pwm_duty_ramp.
//   Handshake: a target is transferred on a rising clock edge where both
//   tgt_valid and tgt_ready are high; tgt_duty is only meaningful while
//   tgt_valid is high, and the master holds tgt_valid/tgt_duty stable until
//   that edge.
//   - tgt_valid : master -> slave, target offered
//   - tgt_duty  : master -> slave, requested duty (clamped by the slave)
//   - tgt_ready : slave -> master, target can be accepted
interface pwm_duty_ramp_if #(
  parameter int DUTY_W = pwm_pkg::DUTY_W_DEF
);
  logic              tgt_valid;
  logic [DUTY_W-1:0] tgt_duty;
  logic              tgt_ready;

  modport master (output tgt_valid, output tgt_duty, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_period_tick.sv
// pwm_period_tick
//   PWM period timebase shared by channel controllers. Owns the period
//   counter, which leaves reset at PERIOD-1 so the very first clock edge
//   after reset is a period boundary.
//   - clk          : clock, rising edge
//   - rst          : asynchronous active-high reset
//   - period_start : high in the first cycle of every PWM period
//   - boundary     : high in the last cycle of a period; the rising edge
//                    that ends this cycle is the boundary edge
module pwm_period_tick #(
  parameter int PERIOD = pwm_pkg::PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic period_start,
  output logic boundary
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] per_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= CNT_LAST;
    end else if (per_cnt == CNT_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

  assign period_start = (per_cnt == '0);
  assign boundary     = (per_cnt == CNT_LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Duty-cycle controller for one PWM channel. Accepts target duties over
//   the tgt handshake and updates the registered duty only on period
//   boundary edges, so no PWM period is ever cut short.
//
//   Build option PWM_DUTY_RAMP_EN:
//     defined   - duty walks one count per STEP_PERIODS boundaries towards
//                 the target (first step on the first boundary edge)
//     undefined - duty jumps straight to the target on the first boundary
//                 edge; no RAMP state, no step counter, STEP_PERIODS unused
//
//   Ports:
//   - clk, rst     : clock (rising edge), asynchronous active-high reset
//   - enable       : channel enable, level; low forces duty to 0 at the next
//                    boundary edge and blocks new targets
//   - tgt          : target handshake (slave side of pwm_duty_ramp_if)
//   - duty         : registered duty for the channel's duty input
//   - period_start : first cycle of each PWM period
//   - busy         : a target is pending or being ramped to
//   - done         : one-cycle pulse, registered on the edge duty hits target
//   - state        : current controller state, for observation
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int PERIOD       = PERIOD_DEF,
  parameter int MAX_DUTY     = MAX_DUTY_DEF,
  parameter int STEP_PERIODS = STEP_PERIODS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  pwm_duty_ramp_if.slave    tgt,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              busy,
  output logic              done,
  output pwm_state_e        state
);

  if (STEP_PERIODS < 1) begin : g_bad_step_periods
    $error("STEP_PERIODS must be at least 1");
  end
  if (MAX_DUTY >= (1 << DUTY_W)) begin : g_bad_max_duty
    $error("MAX_DUTY does not fit in DUTY_W bits");
  end

  logic boundary;

  pwm_period_tick #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .period_start (period_start),
    .boundary     (boundary)
  );

  pwm_state_e        state_q,  state_next;
  logic [DUTY_W-1:0] duty_q,   duty_next;
  logic [DUTY_W-1:0] target_q, target_next;
  logic              done_q,   done_next;
  logic              xfer;
  logic [DUTY_W-1:0] tgt_clamped;

  assign tgt.tgt_ready = enable;
  assign xfer          = tgt.tgt_valid && enable;
  assign tgt_clamped   = DUTY_W'(clamp_duty(duty_wide_t'(tgt.tgt_duty),
                                            duty_wide_t'(MAX_DUTY)));

`ifdef PWM_DUTY_RAMP_EN
  localparam int STEP_W = $clog2(STEP_PERIODS) + 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

  logic [STEP_W-1:0] step_q, step_next;
  logic [DUTY_W-1:0] duty_stepped;

  // Direction is taken from the current target every time, so a target
  // replaced mid-ramp reverses the walk at the next step.
  assign duty_stepped = DUTY_W'(step_toward(duty_wide_t'(duty_q),
                                            duty_wide_t'(target_q)));
`endif

  always_comb begin
    state_next  = state_q;
    duty_next   = duty_q;
    target_next = target_q;
    done_next   = 1'b0;
`ifdef PWM_DUTY_RAMP_EN
    step_next   = step_q;
`endif

    if (boundary && !enable) begin
      // Disable takes priority over any step on the same boundary edge.
      state_next  = IDLE;
      duty_next   = '0;
      target_next = '0;
`ifdef PWM_DUTY_RAMP_EN
      step_next   = '0;
`endif
    end else begin
      if (boundary) begin
        case (state_q)
          ARMED: begin
`ifdef PWM_DUTY_RAMP_EN
            step_next = '0;
            duty_next = duty_stepped;
            if (duty_stepped == target_q) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = RAMP;
            end
`else
            duty_next  = target_q;
            done_next  = 1'b1;
            state_next = IDLE;
`endif
          end
`ifdef PWM_DUTY_RAMP_EN
          RAMP: begin
            if (step_q == STEP_LAST) begin
              step_next = '0;
              duty_next = duty_stepped;
              if (duty_stepped == target_q) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end
            end else begin
              step_next = step_q + STEP_W'(1);
            end
          end
`endif
          default: ;
        endcase
      end

      // The boundary decision above used the old target; a transfer on
      // the same edge only lands in the target register. If the controller
      // is (or is just becoming) idle, the new target waits for the next
      // boundary in ARMED.
      if (xfer) begin
        target_next = tgt_clamped;
        if (state_next == IDLE) begin
          state_next = ARMED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
`ifdef PWM_DUTY_RAMP_EN
      step_q   <= '0;
`endif
    end else begin
      state_q  <= state_next;
      duty_q   <= duty_next;
      target_q <= target_next;
      done_q   <= done_next;
`ifdef PWM_DUTY_RAMP_EN
      step_q   <= step_next;
`endif
    end
  end

  assign duty  = duty_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign state = state_q;

endmodule
